// File: rtl/left_shift_pipe.sv
// Pipelined barrel shifter: SLL / SRL / SRA (and ROL when LEFT_SHIFT_PIPE_ROTATE_EN is defined).
// L = log2(N) register stages; stage k shifts by 2^k when amount bit k is set.
// A single global advance (out_ready | ~out_valid) moves the whole pipeline, bubbles included.
// Without LEFT_SHIFT_PIPE_ROTATE_EN, mode 11 is folded into SLL at the input and no rotate
// logic exists.
module left_shift_pipe #(
  parameter int unsigned N = 32,
  parameter int unsigned L = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   mode,
  input  logic [N-1:0] input1,
  input  logic [N-1:0] input2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] answer,
  output logic         big
);

  localparam logic [1:0] ModeSll = 2'b00;
  localparam logic [1:0] ModeSrl = 2'b01;
  localparam logic [1:0] ModeSra = 2'b10;
  localparam logic [1:0] ModeRol = 2'b11;

  logic [N-1:0] data_q [L];
  logic [N-1:0] data_d [L];
  logic [1:0]   mode_q [L];
  logic [1:0]   mode_d [L];
  logic [L-1:0] amt_q  [L];
  logic [L-1:0] amt_d  [L];
  logic [L-1:0] valid_q, valid_d;
  logic [L-1:0] big_q, big_d;

  logic         advance;
  logic         big_in;
  logic [1:0]   mode_eff;
  logic [N-1:0] data_pre;
  logic         unused_stage;

  // One barrel level: shift d by s according to the operation.
  function automatic logic [N-1:0] shift_by(input logic [N-1:0] d, input logic [1:0] m,
                                            input int unsigned s);
    logic [N-1:0] r;
    case (m)
      ModeSrl: r = d >> s;
      ModeSra: r = N'($signed(d) >>> s);
`ifdef LEFT_SHIFT_PIPE_ROTATE_EN
      ModeRol: r = (d << s) | (d >> (N - s));
`endif
      default: r = d << s;
    endcase
    return r;
  endfunction

  assign advance   = out_ready | ~out_valid;
  assign in_ready  = advance;
  assign out_valid = valid_q[L-1];
  assign answer    = data_q[L-1];
  assign big       = big_q[L-1];

  // Input conditioning: detect amount >= N and pre-load the saturated result so later levels
  // only ever shift zeros or sign copies into it.
  always_comb begin
    big_in   = |(input1 >> L);
    mode_eff = mode;
`ifndef LEFT_SHIFT_PIPE_ROTATE_EN
    if (mode == ModeRol) mode_eff = ModeSll;
`endif
    data_pre = input2;
    if (big_in) begin
      case (mode_eff)
        ModeSll, ModeSrl: data_pre = '0;
        ModeSra:          data_pre = {N{input2[N-1]}};
        default:          data_pre = input2;
      endcase
    end
  end

  // Next-state of every stage; stage 0 fed from the conditioned input.
  always_comb begin
    valid_d[0] = in_valid;
    mode_d[0]  = mode_eff;
    amt_d[0]   = input1[L-1:0];
    big_d[0]   = big_in;
    data_d[0]  = input1[0] ? shift_by(data_pre, mode_eff, 1) : data_pre;
    for (int unsigned k = 1; k < L; k++) begin
      valid_d[k] = valid_q[k-1];
      mode_d[k]  = mode_q[k-1];
      amt_d[k]   = amt_q[k-1];
      big_d[k]   = big_q[k-1];
      data_d[k]  = amt_q[k-1][k] ? shift_by(data_q[k-1], mode_q[k-1], 32'd1 << k)
                                 : data_q[k-1];
    end
  end

  // Amount bits already consumed and the last stage's mode/amount are never read.
  always_comb begin
    unused_stage = 1'b0;
    for (int unsigned k = 0; k < L; k++) begin
      unused_stage = unused_stage ^ (^amt_q[k]) ^ (^mode_q[k]);
    end
  end

  // Pipeline registers; the whole pipe freezes when advance is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      big_q   <= '0;
      for (int unsigned k = 0; k < L; k++) begin
        data_q[k] <= '0;
        mode_q[k] <= ModeSll;
        amt_q[k]  <= '0;
      end
    end else if (advance) begin
      valid_q <= valid_d;
      big_q   <= big_d;
      for (int unsigned k = 0; k < L; k++) begin
        data_q[k] <= data_d[k];
        mode_q[k] <= mode_d[k];
        amt_q[k]  <= amt_d[k];
      end
    end
  end

endmodule
